// File: rtl/memory_stage.sv
// memory_stage: MIPS MEM stage. Registers Execute results, runs the load/store
// against a req/ack data memory, resolves taken branches and pulses WB results.
// Latency: non-memory or misaligned ops give wbValid one cycle after accept.
// Aligned memory ops give wbValid the cycle after the ack, or after abort at
// TIMEOUT request cycles.
// Backpressure: exReady is low for every cycle a memory access is outstanding.
// Ports: clock/reset (sync, active-low); ex* bundle from Execute; dmem* req/ack
// data-memory port; wb*/pcSrc/branchTarget/memError results to Write-Back.
module memory_stage #(
  parameter int TIMEOUT = 255  // 1..255 request cycles before abort
) (
  input  logic        clock,
  input  logic        reset,
  // Execute side
  input  logic        exValid,
  output logic        exReady,
  input  logic [31:0] ALUResult,
  input  logic [31:0] aluReadDataTwo,
  input  logic [4:0]  RdOrRt,
  input  logic        zero,
  input  logic [31:0] addResult,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        branch,
  input  logic        regWrite,
  input  logic        memToReg,
  // data memory
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [31:0] dmemWData,
  input  logic [31:0] dmemRData,
  input  logic        dmemAck,
  // Write-Back side
  output logic        wbValid,
  output logic        wbRegWrite,
  output logic        wbMemToReg,
  output logic [31:0] wbReadData,
  output logic [31:0] wbALUResult,
  output logic [4:0]  wbRd,
  output logic        pcSrc,
  output logic [31:0] branchTarget,
  output logic        memError
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  // Index of the last request cycle allowed before abort (counter starts at 0).
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;

  // Instruction captured at accept; stable for the whole access.
  logic [31:0] l_alu;
  logic [31:0] l_wdata;
  logic [31:0] l_add;
  logic [4:0]  l_rd;
  logic        l_zero, l_mem_read, l_mem_write, l_branch, l_reg_write, l_mem_to_reg;

  logic accept, mem_op_in, aligned_in, start_access, ack_done, abort;

  assign accept       = (state == IDLE) && exValid;
  assign mem_op_in    = memRead | memWrite;
  assign aligned_in   = (ALUResult[1:0] == 2'b00);
  assign start_access = accept && mem_op_in && aligned_in;
  assign ack_done     = (state == ACCESS) && dmemAck;
  // Ack wins over timeout when both land in the same cycle.
  assign abort        = (state == ACCESS) && !dmemAck && (cnt == TMO_LAST);

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_access)       state_nxt = ACCESS;
      ACCESS:  if (ack_done || abort)  state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // Output logic: memory port is only driven while an access is in flight.
  always_comb begin
    exReady   = (state == IDLE);
    dmemReq   = 1'b0;
    dmemWe    = 1'b0;
    dmemAddr  = 32'h0;
    dmemWData = 32'h0;
    if (state == ACCESS) begin
      dmemReq   = 1'b1;
      dmemWe    = l_mem_write;  // write wins when both controls are set
      dmemAddr  = l_alu;
      dmemWData = l_wdata;
    end
  end

  // Request-cycle counter; idles at zero outside ACCESS.
  always_ff @(posedge clock) begin
    if (!reset || state != ACCESS) cnt <= 8'h0;
    else                           cnt <= cnt + 8'h1;
  end

  // Instruction capture
  always_ff @(posedge clock) begin
    if (!reset) begin
      l_alu        <= 32'h0;
      l_wdata      <= 32'h0;
      l_add        <= 32'h0;
      l_rd         <= 5'h0;
      l_zero       <= 1'b0;
      l_mem_read   <= 1'b0;
      l_mem_write  <= 1'b0;
      l_branch     <= 1'b0;
      l_reg_write  <= 1'b0;
      l_mem_to_reg <= 1'b0;
    end else if (accept) begin
      l_alu        <= ALUResult;
      l_wdata      <= aluReadDataTwo;
      l_add        <= addResult;
      l_rd         <= RdOrRt;
      l_zero       <= zero;
      l_mem_read   <= memRead;
      l_mem_write  <= memWrite;
      l_branch     <= branch;
      l_reg_write  <= regWrite;
      l_mem_to_reg <= memToReg;
    end
  end

  // Write-Back result registers. Pulses clear every cycle; fields hold.
  // Ops that need no memory cycle complete straight from the Execute inputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wbValid      <= 1'b0;
      wbRegWrite   <= 1'b0;
      wbMemToReg   <= 1'b0;
      wbReadData   <= 32'h0;
      wbALUResult  <= 32'h0;
      wbRd         <= 5'h0;
      pcSrc        <= 1'b0;
      branchTarget <= 32'h0;
      memError     <= 1'b0;
    end else begin
      wbValid  <= 1'b0;
      pcSrc    <= 1'b0;
      memError <= 1'b0;
      if (accept && !start_access) begin
        // ALU-only op, or a misaligned memory op that never issues a request
        wbValid      <= 1'b1;
        wbRegWrite   <= regWrite && !mem_op_in;
        memError     <= mem_op_in;
        wbMemToReg   <= memToReg;
        wbALUResult  <= ALUResult;
        wbRd         <= RdOrRt;
        pcSrc        <= branch & zero;
        branchTarget <= addResult;
      end else if (ack_done || abort) begin
        wbValid      <= 1'b1;
        wbRegWrite   <= l_reg_write && !abort;
        memError     <= abort;
        wbMemToReg   <= l_mem_to_reg;
        wbALUResult  <= l_alu;
        wbRd         <= l_rd;
        pcSrc        <= l_branch & l_zero;
        branchTarget <= l_add;
        if (ack_done && l_mem_read && !l_mem_write)
          wbReadData <= dmemRData;
      end
    end
  end

endmodule
